// File: rtl/md_pkg.sv
// ============================================================================
// Module   : md_pkg
// Purpose  : Shared opcodes, FSM state encoding and default latencies for the
//            E-stage multiply/divide sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam int C_MULT_CYCLES_DEF = 5;
    localparam int C_DIV_CYCLES_DEF  = 10;
    localparam int C_CNT_W_DEF       = 4;

    // True for the four opcodes that occupy the unit for several cycles.
    function automatic logic md_is_arith(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_cycle_counter.sv
// ============================================================================
// Module   : md_cycle_counter
// Purpose  : Loadable down-counter that flags the final busy cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module md_cycle_counter
    import md_pkg::*;
#(
    parameter int CNT_W = C_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/md_ctrl.sv
// ============================================================================
// Module   : md_ctrl
// Purpose  : E-stage multiply/divide sequencer owning HI/LO, with fixed
//            latency and pipeline stall request. Optional macro
//            MD_DIV0_FAST_EN shortens divide-by-zero to one busy cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = C_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = C_DIV_CYCLES_DEF,
    parameter int CNT_W       = C_CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_mdOp,
    input  logic [31:0] E_rsData,
    input  logic [31:0] E_rtData,
    input  logic        M_cancel,
    input  logic        D_mdUse,
    output logic        E_start,
    output logic        E_busy,
    output logic        md_stall,
    output logic [31:0] E_hiloData,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [CNT_W-1:0] c_mult_load = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_CYCLES);

    logic [1:0]       r_state;
    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;
    logic             r_signed;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_busy;
    logic             w_accept;
    logic             w_mt_wr;
    logic             w_is_mul_op;
    logic             w_done;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_last;
    logic [63:0]      w_prod_s;
    logic [63:0]      w_prod_u;
    logic [31:0]      w_quo_s;
    logic [31:0]      w_rem_s;
    logic [31:0]      w_quo_u;
    logic [31:0]      w_rem_u;

    assign w_busy      = (r_state != S_IDLE);
    assign w_is_mul_op = (E_mdOp == MD_MULT) || (E_mdOp == MD_MULTU);
    // Gating with reset keeps E_start low while reset is held.
    assign w_accept    = reset && !w_busy && md_is_arith(E_mdOp) && !M_cancel;
    assign w_mt_wr     = !w_busy && !M_cancel && ((E_mdOp == MD_MTHI) || (E_mdOp == MD_MTLO));
    assign w_done      = w_busy && w_cnt_last;

    always_comb begin
        w_load_val = w_is_mul_op ? c_mult_load : c_div_load;
`ifdef MD_DIV0_FAST_EN
        if (!w_is_mul_op && (E_rtData == 32'd0)) begin
            w_load_val = CNT_W'(1);
        end
`endif
    end

    md_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_val (w_load_val),
        .i_dec      (w_busy),
        .o_cnt      (w_cnt),
        .o_last     (w_cnt_last)
    );

    // Results are formed from the latched operands at the completing edge.
    assign w_prod_s = $signed({{32{r_op_a[31]}}, r_op_a}) * $signed({{32{r_op_b[31]}}, r_op_b});
    assign w_prod_u = {32'd0, r_op_a} * {32'd0, r_op_b};
    assign w_quo_s  = $signed(r_op_a) / $signed(r_op_b);
    assign w_rem_s  = $signed(r_op_a) % $signed(r_op_b);
    assign w_quo_u  = r_op_a / r_op_b;
    assign w_rem_u  = r_op_a % r_op_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_op_a   <= 32'd0;
            r_op_b   <= 32'd0;
            r_signed <= 1'b0;
        end else if (w_accept) begin
            r_state  <= w_is_mul_op ? S_MUL : S_DIV;
            r_op_a   <= E_rsData;
            r_op_b   <= E_rtData;
            r_signed <= (E_mdOp == MD_MULT) || (E_mdOp == MD_DIV);
        end else if (w_done) begin
            r_state  <= S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_done) begin
            if (r_state == S_MUL) begin
                {r_hi, r_lo} <= r_signed ? w_prod_s : w_prod_u;
            end else if (r_op_b != 32'd0) begin
                r_hi <= r_signed ? w_rem_s : w_rem_u;
                r_lo <= r_signed ? w_quo_s : w_quo_u;
            end
        end else if (w_mt_wr) begin
            if (E_mdOp == MD_MTHI) begin
                r_hi <= E_rsData;
            end else begin
                r_lo <= E_rsData;
            end
        end
    end

    always_comb begin
        E_hiloData = 32'd0;
        if (E_mdOp == MD_MFHI) begin
            E_hiloData = r_hi;
        end else if (E_mdOp == MD_MFLO) begin
            E_hiloData = r_lo;
        end
    end

    assign E_start  = w_accept;
    assign E_busy   = w_busy;
    assign md_stall = D_mdUse && (w_accept || w_busy);
    assign hi_o     = r_hi;
    assign lo_o     = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_ctrl.sv
// ============================================================================
// Module   : tb_md_ctrl
// Purpose  : Directed self-checking bench for md_ctrl (honours
//            MD_DIV0_FAST_EN when defined).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_md_ctrl;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  E_mdOp;
    logic [31:0] E_rsData;
    logic [31:0] E_rtData;
    logic        M_cancel;
    logic        D_mdUse;
    logic        E_start;
    logic        E_busy;
    logic        md_stall;
    logic [31:0] E_hiloData;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;

`ifdef MD_DIV0_FAST_EN
    localparam int C_DIV0_CYCLES = 1;
`else
    localparam int C_DIV0_CYCLES = 10;
`endif

    md_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .E_mdOp     (E_mdOp),
        .E_rsData   (E_rsData),
        .E_rtData   (E_rtData),
        .M_cancel   (M_cancel),
        .D_mdUse    (D_mdUse),
        .E_start    (E_start),
        .E_busy     (E_busy),
        .md_stall   (md_stall),
        .E_hiloData (E_hiloData),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for a single cycle; returns just after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        E_mdOp   = op;
        E_rsData = a;
        E_rtData = b;
        step();
        E_mdOp   = MD_NONE;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        E_mdOp   = MD_MULT;
        E_rsData = 32'd3;
        E_rtData = 32'd4;
        M_cancel = 1'b0;
        D_mdUse  = 1'b1;
        step();
        step();
        checks++; if (E_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", E_start); end
        checks++; if (E_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", E_busy); end
        checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", md_stall); end
        checks++; if ({hi_o, lo_o} !== 64'd0) begin errors++; $display("FAIL reset_hilo got %h exp 0", {hi_o, lo_o}); end
        E_mdOp  = MD_NONE;
        D_mdUse = 1'b0;
        reset   = 1'b1;
        step();
    endtask

    task automatic test_mult();
        E_mdOp   = MD_MULT;
        E_rsData = 32'hFFFF_FFFE;
        E_rtData = 32'd3;
        #1;
        checks++; if (E_start !== 1'b1) begin errors++; $display("FAIL mult_start got %b exp 1", E_start); end
        checks++; if (E_busy !== 1'b0) begin errors++; $display("FAIL mult_busy_pre got %b exp 0", E_busy); end
        step();
        E_mdOp = MD_NONE;
        for (int i = 0; i < 5; i++) begin
            checks++; if (E_busy !== 1'b1 || E_start !== 1'b0) begin errors++; $display("FAIL mult_busy_c%0d got busy=%b start=%b exp 1/0", i, E_busy, E_start); end
            step();
        end
        checks++; if (E_busy !== 1'b0) begin errors++; $display("FAIL mult_busy_end got %b exp 0", E_busy); end
        checks++; if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_hilo got %h_%h exp ffffffff_fffffffa", hi_o, lo_o); end
    endtask

    task automatic test_divu_stall();
        D_mdUse  = 1'b1;
        E_mdOp   = MD_DIVU;
        E_rsData = 32'd100;
        E_rtData = 32'd7;
        #1;
        checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL divu_stall_start got %b exp 1", md_stall); end
        step();
        E_mdOp = MD_NONE;
        for (int i = 0; i < 10; i++) begin
            checks++; if (E_busy !== 1'b1 || md_stall !== 1'b1) begin errors++; $display("FAIL divu_busy_c%0d got busy=%b stall=%b exp 1/1", i, E_busy, md_stall); end
            step();
        end
        checks++; if (E_busy !== 1'b0 || md_stall !== 1'b0) begin errors++; $display("FAIL divu_end got busy=%b stall=%b exp 0/0", E_busy, md_stall); end
        E_mdOp = MD_MFLO;
        #1;
        checks++; if (E_hiloData !== 32'd14) begin errors++; $display("FAIL divu_mflo got %h exp 0000000e", E_hiloData); end
        E_mdOp = MD_MFHI;
        #1;
        checks++; if (E_hiloData !== 32'd2) begin errors++; $display("FAIL divu_mfhi got %h exp 00000002", E_hiloData); end
        E_mdOp  = MD_NONE;
        D_mdUse = 1'b0;
        step();
    endtask

    task automatic test_div_signed();
        int n;
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        n = 0;
        while (E_busy && n < 40) begin n++; step(); end
        checks++; if (n != 10) begin errors++; $display("FAIL div_latency got %0d exp 10", n); end
        checks++; if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_hilo got %h_%h exp ffffffff_fffffffd", hi_o, lo_o); end
    endtask

    task automatic test_div0();
        int n;
        issue(MD_MTHI, 32'd5, 32'd0);
        issue(MD_MTLO, 32'd9, 32'd0);
        checks++; if (hi_o !== 32'd5 || lo_o !== 32'd9) begin errors++; $display("FAIL mt_hilo got %h_%h exp 00000005_00000009", hi_o, lo_o); end
        issue(MD_DIV, 32'd123, 32'd0);
        n = 0;
        while (E_busy && n < 40) begin n++; step(); end
        checks++; if (n != C_DIV0_CYCLES) begin errors++; $display("FAIL div0_latency got %0d exp %0d", n, C_DIV0_CYCLES); end
        checks++; if (hi_o !== 32'd5 || lo_o !== 32'd9) begin errors++; $display("FAIL div0_hilo got %h_%h exp 00000005_00000009", hi_o, lo_o); end
    endtask

    task automatic test_cancel();
        E_mdOp   = MD_MULT;
        E_rsData = 32'd7;
        E_rtData = 32'd8;
        M_cancel = 1'b1;
        #1;
        checks++; if (E_start !== 1'b0) begin errors++; $display("FAIL cancel_start got %b exp 0", E_start); end
        step();
        checks++; if (E_busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b exp 0", E_busy); end
        E_mdOp   = MD_MTHI;
        E_rsData = 32'h1234;
        step();
        checks++; if (hi_o !== 32'd5 || lo_o !== 32'd9) begin errors++; $display("FAIL cancel_hilo got %h_%h exp 00000005_00000009", hi_o, lo_o); end
        M_cancel = 1'b0;
        step();
        E_mdOp = MD_NONE;
        checks++; if (hi_o !== 32'h1234) begin errors++; $display("FAIL mthi got %h exp 00001234", hi_o); end
    endtask

    task automatic test_cancel_busy();
        int n;
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        step();
        step();
        M_cancel = 1'b1;
        step();
        M_cancel = 1'b0;
        n = 3;
        while (E_busy && n < 40) begin n++; step(); end
        checks++; if (n != 5) begin errors++; $display("FAIL multu_latency got %0d exp 5", n); end
        checks++; if (hi_o !== 32'd1 || lo_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hilo got %h_%h exp 00000001_fffffffe", hi_o, lo_o); end
    endtask

    task automatic test_ignore_busy();
        int n;
        issue(MD_MULT, 32'd2, 32'd3);
        E_mdOp   = MD_MTHI;
        E_rsData = 32'd77;
        #1;
        checks++; if (E_start !== 1'b0) begin errors++; $display("FAIL ignore_mt_start got %b exp 0", E_start); end
        step();
        E_mdOp   = MD_DIV;
        E_rsData = 32'd50;
        E_rtData = 32'd5;
        #1;
        checks++; if (E_start !== 1'b0) begin errors++; $display("FAIL ignore_div_start got %b exp 0", E_start); end
        step();
        E_mdOp = MD_NONE;
        n = 2;
        while (E_busy && n < 40) begin n++; step(); end
        checks++; if (n != 5) begin errors++; $display("FAIL ignore_latency got %0d exp 5", n); end
        checks++; if (hi_o !== 32'd0 || lo_o !== 32'd6) begin errors++; $display("FAIL ignore_hilo got %h_%h exp 00000000_00000006", hi_o, lo_o); end
    endtask

    task automatic test_reset_mid();
        issue(MD_DIV, 32'd100, 32'd7);
        step();
        #2;
        reset = 1'b0;
        #1;
        checks++; if (E_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", E_busy); end
        checks++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin errors++; $display("FAIL rstmid_hilo got %h_%h exp 0_0", hi_o, lo_o); end
        step();
        reset = 1'b1;
        step();
        E_mdOp = MD_MFHI;
        #1;
        checks++; if (E_hiloData !== 32'd0 || E_busy !== 1'b0) begin errors++; $display("FAIL rstmid_mfhi got data=%h busy=%b exp 0/0", E_hiloData, E_busy); end
        E_mdOp = MD_NONE;
        step();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divu_stall();
        test_div_signed();
        test_div0();
        test_cancel();
        test_cancel_busy();
        test_ignore_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
Multiply/divide sequencer for the E stage. It owns the HI/LO registers and accepts mult/multu/div/divu/mthi/mtlo from the E-stage instruction. It models a fixed multi-cycle latency with a down-counter and drives the stall request that freezes the D/E pipeline registers while a later md instruction waits. It also suppresses starts and writes when the M stage flushes E because of an exception or interrupt.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
DIV_CYCLES, 10, busy cycles for div/divu (≥1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
E_mdOp  in  4  E-stage md opcode (md_pkg encoding)
E_rsData  in  32  forwarded rs operand
E_rtData  in  32  forwarded rt operand
M_cancel  in  1  flush of E this cycle (exception/interrupt in M)
D_mdUse  in  1  D-stage instruction is any md opcode, including mfhi/mflo
E_start  out  1  md mult/div accepted this cycle (combinational)
E_busy  out  1  multi-cycle operation in flight (registered)
md_stall  out  1  stall request for the pipeline enable logic
E_hiloData  out  32  HI for MFHI, LO for MFLO, else 0 (combinational)
hi_o  out  32  current HI
lo_o  out  32  current LO

Behaviour:
- Opcodes: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO. Codes 9–15 are treated as NONE.
- FSM states: IDLE, MUL, DIV.
- Accept condition: state==IDLE, E_mdOp∈{1..4}, M_cancel==0. E_start = accept.
- On the accept edge:
  - latch operands into op_a/op_b;
  - load cnt with MULT_CYCLES or DIV_CYCLES;
  - go to MUL or DIV.
- E_busy = (state != IDLE). It first rises the cycle after E_start and stays high exactly N cycles.
- Each busy cycle cnt decrements. On the edge where cnt==1:
  - write HI/LO and return to IDLE;
  - new HI/LO are visible the first cycle E_busy is low.
- MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned product.
- DIV: LO = signed quotient, HI = signed remainder, truncating toward zero (remainder takes the dividend's sign). DIVU: unsigned.
- Divide by zero: HI/LO unchanged, full DIV_CYCLES latency, no exception.
- MTHI/MTLO write E_rsData on the edge when state==IDLE and M_cancel==0. There is no busy time.
- md_stall = D_mdUse & (E_start | E_busy).
- M_cancel while busy: the in-flight op is already committed and completes normally. M_cancel only blocks the op currently in E.
- Any md op presented in E while busy is ignored: no start, no write. Bench asserts this never occurs when md_stall is honoured.
- E_hiloData always reads the registered HI/LO. No bypass of in-flight results.
- Reset (asynchronous, mid-operation included) forces immediately:
  - state=IDLE, cnt=0, HI=0, LO=0, op_a=op_b=0;
  - E_busy=0, E_start=0, md_stall=0.

Optional Feature:
MD_DIV0_FAST_EN
- Defined: DIV/DIVU with op_b==0 completes after 1 busy cycle, HI/LO unchanged.
- Undefined: full DIV_CYCLES latency.

Decomposition:
- md_pkg holds:
  - opcode localparams (MD_NONE…MD_MFLO);
  - state encoding (S_IDLE, S_MUL, S_DIV);
  - default cycle constants.
- One natural sub-module: md_cycle_counter. It loads, decrements and flags last-cycle, parameterised by CNT_W. Arithmetic and FSM stay in md_ctrl.

Test Plan:
- MULT, rs=32'hFFFF_FFFE (-2), rt=3 → E_start 1 cycle, E_busy 5 cycles, then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
- DIVU, rs=100, rt=7 → E_busy 10 cycles, then LO=14, HI=2. With D_mdUse=1 (mflo behind it) → md_stall high on the start cycle plus 10 busy cycles, low when LO is valid.
- DIV, rs=-7, rt=2 → LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. DIV by 0 with HI=5, LO=9 → unchanged after 10 cycles, or 1 cycle with MD_DIV0_FAST_EN.
- MULT with M_cancel=1 in the same cycle → E_start=0, E_busy stays 0, HI/LO unchanged. MTHI with rs=32'h1234 and M_cancel=1 → HI unchanged; without cancel → HI=32'h1234 next cycle.
- M_cancel pulsed at busy cycle 3 of MULTU 32'hFFFF_FFFF×2 → completes, HI=1, LO=32'hFFFF_FFFE.
- reset asserted low during busy cycle 2 of DIV → E_busy, HI, LO are 0 immediately (before the next edge). After release, MFHI → E_hiloData=0.
